// File: rtl/tcp_pkg.sv
// ============================================================================
// Module      : tcp_pkg
// Description : Shared types, flag constants and helpers for the TCP TX path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcp_pkg;

    typedef enum logic [2:0] {
        TX_MSG_SEND_SYN  = 3'd0,
        TX_MSG_SEND_ACK  = 3'd1,
        TX_MSG_SEND_DATA = 3'd2,
        TX_MSG_SEND_FIN  = 3'd3,
        TX_MSG_SEND_RST  = 3'd4
    } tx_msg_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DONE = 2'd2
    } tx_state_t;

    localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
    localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
    localparam logic [7:0] TCP_FLAG_RST = 8'h04;
    localparam logic [7:0] TCP_FLAG_PSH = 8'h08;
    localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

    // Unknown encodings collapse to a plain ACK so downstream logic sees only legal types.
    function automatic tx_msg_t tx_msg_norm(input tx_msg_t m);
        tx_msg_t r;
        case (m)
            TX_MSG_SEND_SYN, TX_MSG_SEND_ACK, TX_MSG_SEND_DATA,
            TX_MSG_SEND_FIN, TX_MSG_SEND_RST: r = m;
            default:                          r = TX_MSG_SEND_ACK;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tx_msg_flags(input tx_msg_t m);
        logic [7:0] f;
        case (m)
            TX_MSG_SEND_SYN:  f = TCP_FLAG_SYN;
            TX_MSG_SEND_DATA: f = TCP_FLAG_PSH | TCP_FLAG_ACK;
            TX_MSG_SEND_FIN:  f = TCP_FLAG_FIN | TCP_FLAG_ACK;
            TX_MSG_SEND_RST:  f = TCP_FLAG_RST;
            default:          f = TCP_FLAG_ACK;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcp_iss_lfsr.sv
// ============================================================================
// Module      : tcp_iss_lfsr
// Description : Free-running 32-bit Galois LFSR used as the ISS source.
//               Only compiled when TCP_TX_ISS_LFSR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TCP_TX_ISS_LFSR_EN
module tcp_iss_lfsr #(
    parameter logic [31:0] SEED = 32'hACE1_2345,
    parameter logic [31:0] POLY = 32'h8020_0003
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_value
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value = lfsr_q;

endmodule
`endif

`default_nettype wire

// File: rtl/tcp_tx_ctrl.sv
// ============================================================================
// Module      : tcp_tx_ctrl
// Description : TCP transmit control: latches a request, presents the header
//               field set, and owns SND.NXT. Define TCP_TX_ISS_LFSR_EN to take
//               the ISS from an LFSR instead of the ISS parameter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_tx_ctrl
    import tcp_pkg::*;
#(
    parameter logic [31:0] ISS       = 32'h0000_1000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  tx_msg_t     i_tx_msg,
    input  logic        i_tx_msg_valid,
    output logic        o_tx_msg_ack,
    input  logic [31:0] i_ack_number,
    input  logic [15:0] i_source_port,
    input  logic [15:0] i_dest_port,
    input  logic [15:0] i_window_size,
    input  logic [15:0] i_payload_len,
    output logic [31:0] o_seq_number,
    output logic [31:0] o_ack_number,
    output logic [15:0] o_source_port,
    output logic [15:0] o_dest_port,
    output logic [15:0] o_window_size,
    output logic [7:0]  o_flags,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic [31:0] o_snd_nxt
);

    logic [31:0] w_iss;

`ifdef TCP_TX_ISS_LFSR_EN
    localparam logic [31:0] c_ISS_RST = LFSR_SEED;

    tcp_iss_lfsr #(
        .SEED (LFSR_SEED)
    ) u_iss_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_value (w_iss)
    );

    logic w_unused_iss;
    assign w_unused_iss = ^ISS;
`else
    localparam logic [31:0] c_ISS_RST = ISS;

    assign w_iss = ISS;

    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;
`endif

    tx_state_t   state_q,   state_d;
    tx_msg_t     msg_q,     msg_d;
    logic [31:0] seq_q,     seq_d;
    logic [31:0] ack_q,     ack_d;
    logic [15:0] sport_q,   sport_d;
    logic [15:0] dport_q,   dport_d;
    logic [15:0] win_q,     win_d;
    logic [15:0] len_q,     len_d;
    logic [7:0]  flags_q,   flags_d;
    logic [31:0] snd_nxt_q, snd_nxt_d;

    tx_msg_t     w_msg_in;

    assign w_msg_in = tx_msg_norm(i_tx_msg);

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        seq_d     = seq_q;
        ack_d     = ack_q;
        sport_d   = sport_q;
        dport_d   = dport_q;
        win_d     = win_q;
        len_d     = len_q;
        flags_d   = flags_q;
        snd_nxt_d = snd_nxt_q;

        case (state_q)
            TX_IDLE: begin
                if (i_tx_msg_valid) begin
                    msg_d   = w_msg_in;
                    flags_d = tx_msg_flags(w_msg_in);
                    sport_d = i_source_port;
                    dport_d = i_dest_port;
                    win_d   = i_window_size;
                    len_d   = i_payload_len;
                    if (w_msg_in == TX_MSG_SEND_SYN) begin
                        seq_d = w_iss;
                        ack_d = 32'h0;
                    end else begin
                        seq_d = snd_nxt_q;
                        ack_d = i_ack_number;
                    end
                    state_d = TX_HDR;
                end
            end

            TX_HDR: begin
                if (i_hdr_ready) begin
                    // SND.NXT advances only once the header is handed off.
                    case (msg_q)
                        TX_MSG_SEND_SYN:  snd_nxt_d = seq_q + 32'd1;
                        TX_MSG_SEND_FIN:  snd_nxt_d = snd_nxt_q + 32'd1;
                        TX_MSG_SEND_DATA: snd_nxt_d = snd_nxt_q + {16'h0, len_q};
                        TX_MSG_SEND_RST:  snd_nxt_d = w_iss;
                        default:          snd_nxt_d = snd_nxt_q;
                    endcase
                    state_d = TX_DONE;
                end
            end

            TX_DONE: begin
                state_d = TX_IDLE;
            end

            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= TX_IDLE;
            msg_q     <= TX_MSG_SEND_ACK;
            seq_q     <= 32'h0;
            ack_q     <= 32'h0;
            sport_q   <= 16'h0;
            dport_q   <= 16'h0;
            win_q     <= 16'h0;
            len_q     <= 16'h0;
            flags_q   <= 8'h0;
            snd_nxt_q <= c_ISS_RST;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            seq_q     <= seq_d;
            ack_q     <= ack_d;
            sport_q   <= sport_d;
            dport_q   <= dport_d;
            win_q     <= win_d;
            len_q     <= len_d;
            flags_q   <= flags_d;
            snd_nxt_q <= snd_nxt_d;
        end
    end

    assign o_hdr_valid   = (state_q == TX_HDR);
    assign o_tx_msg_ack  = (state_q == TX_DONE);
    assign o_seq_number  = seq_q;
    assign o_ack_number  = ack_q;
    assign o_source_port = sport_q;
    assign o_dest_port   = dport_q;
    assign o_window_size = win_q;
    assign o_flags       = flags_q;
    assign o_snd_nxt     = snd_nxt_q;

endmodule

`default_nettype wire
